// File: rtl/vga_pixel_to_cell.sv
`default_nettype none
// ============================================================================
// vga_pixel_to_cell: decodes a VGA pixel (linha, coluna) into the 8x8 grid cell
// it falls in, walking columns then rows with running border accumulators.
// Revision 1.0 - initial release
// ============================================================================
module vga_pixel_to_cell #(
  parameter int X0     = 16,
  parameter int XPITCH = 62,
  parameter int CELL_W = 49,
  parameter int Y0     = 16,
  parameter int YPITCH = 57,
  parameter int CELL_H = 54,
  parameter int N      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [9:0]  linha,
  input  logic [9:0]  coluna,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [19:0] celula
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_SCAN_X  = 2'd1;
  localparam logic [1:0]  c_SCAN_Y  = 2'd2;
  localparam logic [1:0]  c_DONE    = 2'd3;
  localparam logic [10:0] c_X0      = 11'(X0);
  localparam logic [10:0] c_XPITCH  = 11'(XPITCH);
  localparam logic [10:0] c_CELL_W  = 11'(CELL_W);
  localparam logic [10:0] c_Y0      = 11'(Y0);
  localparam logic [10:0] c_YPITCH  = 11'(YPITCH);
  localparam logic [10:0] c_CELL_H  = 11'(CELL_H);
  localparam logic [3:0]  c_N       = 4'(N);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [10:0] acc_q, acc_d;
  logic [9:0]  lin_q, lin_d;
  logic [9:0]  col_q, col_d;
  logic [3:0]  xcell_q, xcell_d;
  logic        hit_q, hit_d;
  logic [19:0] celula_q, celula_d;

  logic [10:0] w_coord;
  logic [10:0] w_ext;
  logic        w_match;
  logic        w_last;

  // 11-bit compare keeps border+extent from wrapping
  assign w_coord = (state_q == c_SCAN_X) ? {1'b0, col_q} : {1'b0, lin_q};
  assign w_ext   = (state_q == c_SCAN_X) ? c_CELL_W : c_CELL_H;
  assign w_match = (w_coord > acc_q) && (w_coord < (acc_q + w_ext));
  assign w_last  = (idx_q == c_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:   if (req) state_d = c_SCAN_X;
      c_SCAN_X: begin
        if (w_match)     state_d = c_SCAN_Y;
        else if (w_last) state_d = c_DONE;
      end
      c_SCAN_Y: if (w_match || w_last) state_d = c_DONE;
      default:  state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == c_SCAN_X) || (state_q == c_SCAN_Y);
    done   = (state_q == c_DONE);
    hit    = hit_q;
    celula = celula_q;
  end

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    lin_d    = lin_q;
    col_d    = col_q;
    xcell_d  = xcell_q;
    hit_d    = hit_q;
    celula_d = celula_q;
    case (state_q)
      c_IDLE: begin
        if (req) begin
          lin_d    = linha;
          col_d    = coluna;
          idx_d    = 4'd1;
          acc_d    = c_X0;
          xcell_d  = 4'd0;
          hit_d    = 1'b0;
          celula_d = 20'd0;
        end
      end
      c_SCAN_X: begin
        if (w_match) begin
          xcell_d = idx_q;
          idx_d   = 4'd1;
          acc_d   = c_Y0;
        end else if (!w_last) begin
          idx_d = idx_q + 4'd1;
          acc_d = acc_q + c_XPITCH;
        end
      end
      c_SCAN_Y: begin
        if (w_match) begin
          hit_d    = 1'b1;
          celula_d = {9'd0, idx_q, xcell_q, 3'd0};
        end else if (!w_last) begin
          idx_d = idx_q + 4'd1;
          acc_d = acc_q + c_YPITCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 4'd0;
      acc_q    <= 11'd0;
      lin_q    <= 10'd0;
      col_q    <= 10'd0;
      xcell_q  <= 4'd0;
      hit_q    <= 1'b0;
      celula_q <= 20'd0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      lin_q    <= lin_d;
      col_q    <= col_d;
      xcell_q  <= xcell_d;
      hit_q    <= hit_d;
      celula_q <= celula_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_to_cell.sv
`default_nettype none
// ============================================================================
// tb_vga_pixel_to_cell: scoreboard bench for the pixel-to-cell decoder.
// Revision 1.0 - initial release
// ============================================================================
module tb_vga_pixel_to_cell;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [9:0]  linha = 10'd0;
  logic [9:0]  coluna = 10'd0;
  logic        busy;
  logic        done;
  logic        hit;
  logic [19:0] celula;

  typedef struct {
    int          cyc;
    logic        hit;
    logic [19:0] cel;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ndone = 0;
  int   exp_done = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc;

  vga_pixel_to_cell dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .linha  (linha),
    .coluna (coluna),
    .busy   (busy),
    .done   (done),
    .hit    (hit),
    .celula (celula)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req_v, req_v);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("hit", int'(hit), int'(e.hit));
        chk("celula", int'(celula), int'(e.cel));
      end
      ndone++;
    end
  end

  // issue a request; on return the bench sits #1 into cycle 1
  task automatic req_cell(input logic [9:0] c, input logic [9:0] l, input int lat,
                          input logic h, input logic [19:0] cel, input bit push);
    @(negedge clk);
    coluna = c;
    linha  = l;
    req    = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req    = 1'b0;
    coluna = 10'h3FF;
    linha  = 10'h3FF;
    if (push) begin
      q.push_back('{acc_cyc + lat - 1, h, cel});
      exp_done++;
    end
  endtask

  task automatic wait_done(input logic h, input logic [19:0] cel);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (ndone >= exp_done) break;
    end
    #1;
    chk("done_count", ndone, exp_done);
    chk("hit_held", int'(hit), int'(h));
    chk("celula_held", int'(celula), int'(cel));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_celula", int'(celula), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // X1,Y1 with busy profile
    req_cell(10'd20, 10'd20, 3, 1'b1, 20'h00088, 1'b1);
    chk("busy_c1", int'(busy), 1);
    @(posedge clk); #1;
    chk("busy_c2", int'(busy), 1);
    @(posedge clk); #1;
    chk("busy_c3", int'(busy), 0);
    wait_done(1'b1, 20'h00088);

    req_cell(10'd460, 10'd420, 17, 1'b1, 20'h00440, 1'b1);
    wait_done(1'b1, 20'h00440);

    req_cell(10'd16, 10'd20, 9, 1'b0, 20'h0, 1'b1);
    wait_done(1'b0, 20'h0);
    req_cell(10'd65, 10'd20, 9, 1'b0, 20'h0, 1'b1);
    wait_done(1'b0, 20'h0);
    req_cell(10'd70, 10'd20, 9, 1'b0, 20'h0, 1'b1);
    wait_done(1'b0, 20'h0);

    // row gap after X2 match
    req_cell(10'd100, 10'd71, 11, 1'b0, 20'h0, 1'b1);
    wait_done(1'b0, 20'h0);

    // req held high during cycles 1-5 of a scan must be ignored
    req_cell(10'd460, 10'd420, 17, 1'b1, 20'h00440, 1'b1);
    coluna = 10'd20;
    linha  = 10'd20;
    req    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req = 1'b0;
    wait_done(1'b1, 20'h00440);
    repeat (20) @(posedge clk);
    #1;
    chk("no_extra_done", ndone, exp_done);

    // reset in cycle 4 of an (X8,Y8) request
    req_cell(10'd460, 10'd420, 17, 1'b1, 20'h00440, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_hit", int'(hit), 0);
    chk("midrst_celula", int'(celula), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("aborted_no_done", ndone, exp_done);

    req_cell(10'd330, 10'd305, 13, 1'b1, 20'h00330, 1'b1);
    wait_done(1'b1, 20'h00330);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
